// File: rtl/instr_sequencer_if.sv
// Handshake/bus bundle between the host side and the instruction sequencer.
// master: drives run, mem_data, done_vec and valid_op; slave: the sequencer.
interface instr_sequencer_if;
   localparam int unsigned WORD_W = 16;

   logic              run;
   logic [WORD_W-1:0] mem_data;
   logic [WORD_W-1:0] done_vec;
   logic [WORD_W-1:0] valid_op;
   logic              ir_load;
   logic [WORD_W-1:0] ir;
   logic [WORD_W-1:0] start;
   logic              busy;
   logic              halted;
   logic              illegal;
   logic              fault;

   modport master (
      output run, mem_data, done_vec, valid_op,
      input  ir_load, ir, start, busy, halted, illegal, fault
   );

   modport slave (
      input  run, mem_data, done_vec, valid_op,
      output ir_load, ir, start, busy, halted, illegal, fault
   );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a word, decodes its opcode (ir[15:12]) and
// enables the matching instruction FSM until that FSM reports done.
// Optional watchdog on EXEC length: define INSTR_SEQ_WDT_EN to enable it.
// Every output is a register loaded from the next-state decode, so no
// input reaches an output combinationally.
module instr_sequencer #(
   parameter logic [3:0]  HALT_OP    = 4'b1111,
   parameter int unsigned WDT_CYCLES = 32
) (
   input logic               clk,
   input logic               rst,
   instr_sequencer_if.slave  bus
);
   localparam int unsigned WORD_W = 16;
   localparam int unsigned OP_W   = 4;

   localparam logic [2:0] S_IDLE   = 3'b000;
   localparam logic [2:0] S_FETCH  = 3'b001;
   localparam logic [2:0] S_DECODE = 3'b010;
   localparam logic [2:0] S_EXEC   = 3'b011;
   localparam logic [2:0] S_HALT   = 3'b100;
   localparam logic [2:0] S_ERR    = 3'b101;

   // A zero-length watchdog window is meaningless; reject it at elaboration.
   if (WDT_CYCLES < 1) begin : g_wdt_cfg_chk
      $error("WDT_CYCLES must be at least 1");
   end

   logic [2:0]        state_q, state_d;
   logic [WORD_W-1:0] ir_q, ir_d;
   logic [WORD_W-1:0] start_q, start_d;
   logic              ir_load_q, ir_load_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic [OP_W-1:0]   op;
   logic [OP_W-1:0]   op_d;

`ifdef INSTR_SEQ_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);
   logic [WDT_W-1:0] wdt_q, wdt_d;
   logic             fault_q, fault_d;
`endif

   assign op   = ir_q[WORD_W-1 -: OP_W];
   assign op_d = ir_d[WORD_W-1 -: OP_W];

   // Next-state, instruction register and registered-output decode.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
`ifdef INSTR_SEQ_WDT_EN
      wdt_d     = wdt_q;
      fault_d   = fault_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = bus.mem_data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            // HALT_OP wins even if its valid_op bit is set.
            if (op == HALT_OP) begin
               state_d = S_HALT;
            end else if (!bus.valid_op[op]) begin
               state_d   = S_ERR;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EXEC;
`ifdef INSTR_SEQ_WDT_EN
               wdt_d   = '0;
`endif
            end
         end
         S_EXEC: begin
            // Only the selected opcode's done bit matters; run is sampled here.
            if (bus.done_vec[op]) begin
               state_d = bus.run ? S_FETCH : S_IDLE;
`ifdef INSTR_SEQ_WDT_EN
            end else if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
               state_d = S_ERR;
               fault_d = 1'b1;
            end else begin
               wdt_d = wdt_q + WDT_W'(1);
`endif
            end
         end
         S_HALT:  state_d = S_HALT;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase

      ir_load_d = (state_d == S_FETCH);
      busy_d    = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC);
      halted_d  = (state_d == S_HALT);
      start_d   = (state_d == S_EXEC) ? (WORD_W'(1) << op_d) : '0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         start_q   <= '0;
         ir_load_q <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
`ifdef INSTR_SEQ_WDT_EN
         wdt_q     <= '0;
         fault_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         start_q   <= start_d;
         ir_load_q <= ir_load_d;
         busy_q    <= busy_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
`ifdef INSTR_SEQ_WDT_EN
         wdt_q     <= wdt_d;
         fault_q   <= fault_d;
`endif
      end
   end

   assign bus.ir      = ir_q;
   assign bus.start   = start_q;
   assign bus.ir_load = ir_load_q;
   assign bus.busy    = busy_q;
   assign bus.halted  = halted_q;
   assign bus.illegal = illegal_q;
`ifdef INSTR_SEQ_WDT_EN
   assign bus.fault   = fault_q;
`else
   assign bus.fault   = 1'b0;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer. Each accepted instruction pushes
// its expected ir/start onto a scoreboard; a monitor pops and compares when
// start rises. Directed checks cover reset, halt, illegal, run/done handling.
module tb_instr_sequencer;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   instr_sequencer_if bus ();

   instr_sequencer #(
      .HALT_OP    (4'hF),
      .WDT_CYCLES (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] ir;
      logic [15:0] start;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_mis = 0;
   logic [15:0] prev_start = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] onehot(input logic [15:0] word);
      logic [3:0] o;
      o = word[15:12];
      return 16'd1 << o;
   endfunction

   task automatic push_instr(input logic [15:0] word);
      exp_t e;
      e.ir    = word;
      e.start = onehot(word);
      sb_q.push_back(e);
   endtask

   // Hold rst for two edges with the given program, then release.
   task automatic reset_with(input logic [15:0] word, input logic [15:0] vmask, input logic r);
      rst          = 1'b1;
      bus.run      = r;
      bus.mem_data = word;
      bus.valid_op = vmask;
      bus.done_vec = '0;
      tick(2);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: compare on every rising start.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.start != 16'h0 && prev_start == 16'h0) begin
            if (sb_q.size() == 0) begin
               check("sb_unexpected_start", 32'(bus.start), 32'h0);
            end else begin
               e = sb_q.pop_front();
               check("sb_start", 32'(bus.start), 32'(e.start));
               check("sb_ir", 32'(bus.ir), 32'(e.ir));
            end
         end
         prev_start = bus.start;
      end
   end

   initial begin
      rst          = 1'b1;
      bus.run      = 1'b0;
      bus.mem_data = '0;
      bus.done_vec = '0;
      bus.valid_op = '0;

      // Basic instruction: 7085, done on the 2nd EXEC cycle.
      rst = 1'b1; bus.run = 1'b1; bus.mem_data = 16'h7085; bus.valid_op = 16'h0080;
      tick(2);
      check("rst_outputs", {bus.ir_load, bus.busy, bus.halted, bus.illegal, bus.fault}, 5'b0);
      check("rst_ir", 32'(bus.ir), 32'h0);
      check("rst_start", 32'(bus.start), 32'h0);
      rst = 1'b0;
      push_instr(16'h7085);
      tick();
      check("fetch_irload", {bus.ir_load, bus.busy}, 2'b11);
      check("fetch_ir_unchanged", 32'(bus.ir), 32'h0);
      tick();
      check("decode_irload", bus.ir_load, 1'b0);
      check("decode_ir", 32'(bus.ir), 32'h7085);
      check("decode_start", 32'(bus.start), 32'h0);
      tick();
      check("exec1_start", 32'(bus.start), 32'h0080);
      tick();
      check("exec2_start", 32'(bus.start), 32'h0080);
      bus.done_vec = 16'h0080;
      tick();
      bus.done_vec = '0;
      check("refetch", {bus.ir_load, bus.busy}, 2'b11);
      check("refetch_start", 32'(bus.start), 32'h0);

      // Foreign done ignored; run low does not abort; done then exits to IDLE.
      push_instr(16'h7085);
      tick(2);
      check("exec_b1_start", 32'(bus.start), 32'h0080);
      bus.done_vec = 16'h0004;
      tick();
      bus.done_vec = '0;
      bus.run      = 1'b0;
      check("foreign_done_ignored", 32'(bus.start), 32'h0080);
      tick();
      check("run_low_no_abort", {bus.busy, bus.start}, {1'b1, 16'h0080});
      bus.done_vec = 16'h0080;
      tick();
      bus.done_vec = '0;
      check("exit_idle", {bus.busy, bus.ir_load, bus.start}, 18'h0);
      tick(3);
      check("idle_stays", {bus.busy, bus.ir_load}, 2'b00);

      // HALT has priority over valid_op and ignores done_vec until reset.
      reset_with(16'hF000, 16'hFFFF, 1'b1);
      tick(3);
      check("halt_entry", {bus.halted, bus.busy, bus.illegal, bus.start}, {3'b100, 16'h0});
      bus.done_vec = 16'hFFFF;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("halt_hold", {bus.halted, bus.busy, bus.ir_load, bus.start}, {3'b100, 16'h0});
      end
      bus.done_vec = '0;
      rst = 1'b1;
      tick();
      check("halt_cleared", bus.halted, 1'b0);

      // Unimplemented opcode -> ERR, start never asserts.
      reset_with(16'h3000, 16'h0080, 1'b1);
      tick(3);
      check("err_entry", {bus.illegal, bus.halted, bus.busy, bus.fault}, 4'b1000);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("err_hold", {bus.illegal, bus.start}, {1'b1, 16'h0});
      end
      rst = 1'b1;
      tick();
      check("err_cleared", bus.illegal, 1'b0);

      // Reset in the 3rd EXEC cycle overrides done; then wait for run.
      reset_with(16'h7085, 16'h0080, 1'b1);
      push_instr(16'h7085);
      tick(5);
      check("exec3_start", 32'(bus.start), 32'h0080);
      rst = 1'b1;
      bus.done_vec = 16'h0080;
      tick();
      check("midexec_rst", {bus.busy, bus.ir_load, bus.start}, 18'h0);
      check("midexec_rst_ir", 32'(bus.ir), 32'h0);
      rst = 1'b0;
      bus.run = 1'b0;
      bus.done_vec = '0;
      tick(4);
      check("idle_until_run", {bus.busy, bus.ir_load}, 2'b00);
      bus.run = 1'b1;
      tick();
      check("run_fetch", bus.ir_load, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;

`ifdef INSTR_SEQ_WDT_EN
      // Watchdog expires after 4 EXEC cycles without done.
      reset_with(16'h7085, 16'h0080, 1'b1);
      push_instr(16'h7085);
      tick(6);
      check("wdt_exec4", {bus.fault, bus.start}, {1'b0, 16'h0080});
      tick();
      check("wdt_fault", {bus.fault, bus.illegal, bus.busy, bus.start}, {3'b100, 16'h0});
      tick(3);
      check("wdt_fault_hold", bus.fault, 1'b1);
      // Done on the 4th cycle beats the watchdog.
      reset_with(16'h7085, 16'h0080, 1'b1);
      push_instr(16'h7085);
      tick(6);
      bus.done_vec = 16'h0080;
      tick();
      bus.done_vec = '0;
      check("wdt_done_wins", {bus.fault, bus.ir_load, bus.busy}, 3'b011);
      rst = 1'b1;
      tick();
      rst = 1'b0;
`else
      // No watchdog: EXEC waits indefinitely and fault stays low.
      reset_with(16'h7085, 16'h0080, 1'b1);
      push_instr(16'h7085);
      tick(3);
      bus.run = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         check("no_wdt_wait", {bus.fault, bus.busy, bus.start}, {2'b01, 16'h0080});
      end
      bus.done_vec = 16'h0080;
      tick();
      bus.done_vec = '0;
      check("no_wdt_exit", {bus.fault, bus.busy, bus.start}, 18'h0);
`endif

      tick(2);
      check("sb_drain", 32'(sb_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
